// File: rtl/disp_pkg.sv
// Shared constants, digit codes and segment decode for the seven-segment display peripheral.
package disp_pkg;

  localparam logic AddrData = 1'b0;
  localparam logic AddrCtrl = 1'b1;

  // Digit codes 0-15 are hex values; two extra codes for blank and dash.
  typedef logic [4:0] digit_t;
  localparam digit_t DigBlank = 5'd16;
  localparam digit_t DigDash  = 5'd17;

  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegDash  = 7'h3F;

  typedef enum logic {MODE_HEX = 1'b0, MODE_DEC = 1'b1} mode_e;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} conv_state_e;

  // Active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(digit_t code);
    logic [6:0] seg;
    case (code)
      5'd0:    seg = 7'h40;
      5'd1:    seg = 7'h79;
      5'd2:    seg = 7'h24;
      5'd3:    seg = 7'h30;
      5'd4:    seg = 7'h19;
      5'd5:    seg = 7'h12;
      5'd6:    seg = 7'h02;
      5'd7:    seg = 7'h78;
      5'd8:    seg = 7'h00;
      5'd9:    seg = 7'h10;
      5'd10:   seg = 7'h08;
      5'd11:   seg = 7'h03;
      5'd12:   seg = 7'h46;
      5'd13:   seg = 7'h21;
      5'd14:   seg = 7'h06;
      5'd15:   seg = 7'h0E;
      DigDash: seg = SegDash;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to 5 BCD digits, one LOAD then 16 SHIFT cycles.
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);

  conv_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [19:0] bcd_adj, bcd_step;
  logic        unused_adj_msb;

  assign unused_adj_msb = bcd_adj[19];

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    bcd_step = {bcd_adj[18:0], bin_q[15]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        bcd_d = bcd_step;
        bin_d = {bin_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = StDone;
          done    = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A new write always wins over an in-flight conversion.
    if (start) begin
      state_d = StLoad;
      bin_d   = bin;
      done    = 1'b0;
    end else if (abort) begin
      state_d = StIdle;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = (state_q == StLoad) || (state_q == StShift);
  // Final digits are taken from the last shift so the commit lands as busy falls.
  assign bcd  = bcd_step;

endmodule

// File: rtl/seg_display_ctrl.sv
// Memory-mapped 8-digit seven-segment display: DATA/CTRL registers, hex or decimal
// display with leading-zero blanking, and a registered refresh scan.
module seg_display_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 10_000_000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned SIMULACION = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [6:0]  SEG,
  output logic [7:0]  AN
);

  localparam int unsigned TickDiv = (SIMULACION != 0) ? 4 : CLK_HZ / (REFRESH_HZ * 8);
  localparam int unsigned DivW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;

  mode_e            mode_q, mode_d;
  logic             lzb_q, lzb_d;
  logic [7:0]       mask_q, mask_d;
  digit_t [7:0]     disp_buf_q, disp_buf_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       idx_q, idx_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [6:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;
  logic [31:0]      rdata_q;

  logic        data_wr, ctrl_wr, conv_start, conv_abort, conv_done;
  logic [19:0] conv_bcd;
  logic [7:0]  lead_zero;
  digit_t      cur_code;

  assign data_wr    = we && (addr == AddrData);
  assign ctrl_wr    = we && (addr == AddrCtrl);
  assign conv_start = data_wr && (mode_q == MODE_DEC) && (wdata[31:16] == 16'd0);
  assign conv_abort = data_wr && !conv_start;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .abort (conv_abort),
    .bin   (wdata[15:0]),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    mode_d     = mode_q;
    lzb_d      = lzb_q;
    mask_d     = mask_q;
    disp_buf_d = disp_buf_q;
    ovf_d      = ovf_q;
    if (ctrl_wr) begin
      mode_d = mode_e'(wdata[0]);
      lzb_d  = wdata[1];
      mask_d = wdata[15:8];
    end
    if (data_wr) begin
      if (mode_q == MODE_HEX) begin
        for (int i = 0; i < 8; i++) disp_buf_d[i] = {1'b0, wdata[4*i +: 4]};
        ovf_d = 1'b0;
      end else if (wdata[31:16] != 16'd0) begin
        for (int i = 0; i < 8; i++) disp_buf_d[i] = DigDash;
        ovf_d = 1'b1;
      end
    end else if (conv_done) begin
      for (int i = 0; i < 8; i++) begin
        disp_buf_d[i] = (i < 5) ? {1'b0, conv_bcd[4*i +: 4]} : DigBlank;
      end
      ovf_d = 1'b0;
    end
  end

  // Blank codes count as zero so unused decimal digits fold into the blanked run.
  always_comb begin
    lead_zero    = '0;
    lead_zero[7] = (disp_buf_q[7] == 5'd0) || (disp_buf_q[7] == DigBlank);
    for (int i = 6; i >= 0; i--) begin
      lead_zero[i] = ((disp_buf_q[i] == 5'd0) || (disp_buf_q[i] == DigBlank)) && lead_zero[i+1];
    end
  end

  always_comb begin
    div_d = div_q + DivW'(1);
    idx_d = idx_q;
    if (div_q == DivW'(TickDiv - 1)) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
    end
    cur_code = (lzb_q && lead_zero[idx_q] && (idx_q != 3'd0)) ? DigBlank : disp_buf_q[idx_q];
    if (mask_q[idx_q]) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = seg_decode(cur_code);
    end else begin
      an_d  = 8'hFF;
      seg_d = SegBlank;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q     <= MODE_HEX;
      lzb_q      <= 1'b0;
      mask_q     <= 8'hFF;
      disp_buf_q <= '0;
      ovf_q      <= 1'b0;
      idx_q      <= '0;
      div_q      <= '0;
      seg_q      <= SegBlank;
      an_q       <= 8'hFF;
      rdata_q    <= '0;
    end else begin
      mode_q     <= mode_d;
      lzb_q      <= lzb_d;
      mask_q     <= mask_d;
      disp_buf_q <= disp_buf_d;
      ovf_q      <= ovf_d;
      idx_q      <= idx_d;
      div_q      <= div_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      rdata_q    <= {30'b0, ovf_q, busy};
    end
  end

  assign SEG   = seg_q;
  assign AN    = an_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: per-cycle reference model plus directed literal checks.
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic [6:0]  SEG;
  logic [7:0]  AN;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  seg_display_ctrl #(
    .CLK_HZ     (10_000_000),
    .REFRESH_HZ (1000),
    .SIMULACION (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .busy  (busy),
    .SEG   (SEG),
    .AN    (AN)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int code);
    case (code)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; 15: return 7'h0E;
      17: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference model: digit values as integers, scan position from the cycle count.
  int          m_buf [8];
  int          m_cyc, m_cnt, m_pend, m_idx, m_code, m_v;
  bit          m_dec, m_lzb, m_ovf, m_lead;
  logic [7:0]  m_mask, m_an;
  logic [6:0]  m_seg;
  logic [31:0] m_rdata;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cyc = 0; m_cnt = 0; m_ovf = 0; m_lzb = 0; m_dec = 0; m_mask = 8'hFF;
      for (int j = 0; j < 8; j++) m_buf[j] = 0;
      m_an = 8'hFF; m_seg = 7'h7F; m_rdata = 0;
    end else begin
      m_idx  = (m_cyc / 4) % 8;
      m_lead = 1;
      for (int j = 7; j > m_idx; j--) if (!(m_buf[j] == 0 || m_buf[j] == 16)) m_lead = 0;
      m_code = m_buf[m_idx];
      if (m_lzb && m_idx != 0 && m_lead && (m_code == 0 || m_code == 16)) m_code = 16;
      if (m_mask[m_idx]) begin
        m_an  = ~(8'(1) << m_idx);
        m_seg = seg_of(m_code);
      end else begin
        m_an  = 8'hFF;
        m_seg = 7'h7F;
      end
      m_rdata = {30'b0, m_ovf, (m_cnt > 0)};
      m_cyc++;
      if (we && addr == 1'b1) begin
        m_dec = wdata[0]; m_lzb = wdata[1]; m_mask = wdata[15:8];
      end else if (we) begin
        m_cnt = 0;
        if (!m_dec) begin
          for (int j = 0; j < 8; j++) m_buf[j] = (wdata >> (4 * j)) & 32'hF;
          m_ovf = 0;
        end else if (wdata > 32'd65535) begin
          for (int j = 0; j < 8; j++) m_buf[j] = 17;
          m_ovf = 1;
        end else begin
          m_pend = wdata;
          m_cnt  = 17;
        end
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_v = m_pend;
          for (int j = 0; j < 5; j++) begin
            m_buf[j] = m_v % 10;
            m_v      = m_v / 10;
          end
          for (int j = 5; j < 8; j++) m_buf[j] = 16;
          m_ovf = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("an", {24'b0, AN}, {24'b0, m_an});
      check("seg", {25'b0, SEG}, {25'b0, m_seg});
      check("busy", {31'b0, busy}, {31'b0, (m_cnt > 0)});
      check("rdata", rdata, m_rdata);
    end
  end

  task automatic bus_write(input logic a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic check_digit(input string name, input int d, input logic [6:0] exp);
    logic [7:0] want;
    bit         ok;
    want = ~(8'(1) << d);
    ok   = 0;
    for (int k = 0; k < 80 && !ok; k++) begin
      @(negedge clk);
      if (AN == want) begin
        ok = 1;
        check(name, {25'b0, SEG}, {25'b0, exp});
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s: digit %0d never scanned, required SEG %h", name, d, exp);
    end
  endtask

  int bad_an;

  initial begin
    reset = 1'b0; we = 1'b0; addr = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_an", {24'b0, AN}, 32'hFF);
    check("rst_seg", {25'b0, SEG}, 32'h7F);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_rdata", rdata, 32'h0);

    // 1: scan walk after release
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("walk_fe", {24'b0, AN}, 32'hFE);
    check("walk_seg0", {25'b0, SEG}, 32'h40);
    repeat (4) @(negedge clk);
    check("walk_fd", {24'b0, AN}, 32'hFD);
    repeat (27) @(negedge clk);
    check("walk_7f", {24'b0, AN}, 32'h7F);
    @(negedge clk);
    check("walk_wrap", {24'b0, AN}, 32'hFE);

    // 2: hex data
    bus_write(1'b0, 32'h1234_ABCD);
    check_digit("hex_d0", 0, 7'h21);
    check_digit("hex_d7", 7, 7'h79);
    check_digit("hex_d4", 4, 7'h19);
    check("hex_ovf", rdata, 32'h0);

    // 3: decimal with blanking
    bus_write(1'b1, 32'h0000_FF03);
    bus_write(1'b0, 32'd40);
    check("dec_busy_rise", {31'b0, busy}, 32'h1);
    repeat (16) @(negedge clk);
    check("dec_busy_16", {31'b0, busy}, 32'h1);
    @(negedge clk);
    check("dec_busy_17", {31'b0, busy}, 32'h0);
    check_digit("dec40_d1", 1, 7'h19);
    check_digit("dec40_d0", 0, 7'h40);
    check_digit("dec40_d2", 2, 7'h7F);
    check_digit("dec40_d7", 7, 7'h7F);

    // 4: max value then overflow
    bus_write(1'b0, 32'd65535);
    repeat (20) @(negedge clk);
    check_digit("dec_max_d4", 4, 7'h02);
    check_digit("dec_max_d0", 0, 7'h12);
    bus_write(1'b0, 32'h0001_0000);
    check("ovf_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    check("ovf_rdata", rdata, 32'h2);
    check_digit("ovf_dash", 3, 7'h3F);

    // 5: restart mid-conversion
    bus_write(1'b0, 32'd12345);
    repeat (4) @(negedge clk);
    bus_write(1'b0, 32'd7);
    repeat (16) @(negedge clk);
    check("restart_busy_16", {31'b0, busy}, 32'h1);
    @(negedge clk);
    check("restart_busy_17", {31'b0, busy}, 32'h0);
    check_digit("restart_d0", 0, 7'h78);
    check_digit("restart_d1", 1, 7'h7F);

    // 6: digit mask, then reset mid-conversion
    bus_write(1'b1, 32'h0000_0F03);
    bad_an = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (AN[7:4] != 4'hF) bad_an++;
    end
    check("mask_hi_off", bad_an, 0);
    check_digit("mask_d0", 0, 7'h78);
    bus_write(1'b0, 32'd999);
    repeat (5) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    check("mid_rst_an", {24'b0, AN}, 32'hFF);
    check("mid_rst_seg", {25'b0, SEG}, 32'h7F);
    check("mid_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
Memory-mapped 8-digit seven-segment display peripheral, directly downstream of the CPU store path: consumes the display write strobe and write data produced by the core/bus decoder and drives the board SEG/AN pins. It holds a data register and a control register and converts values to decimal on request. It time-multiplexes the digits with a refresh scan.

Parameters:
CLK_HZ, 10_000_000, frequency of clk in Hz
REFRESH_HZ, 1000, full 8-digit refresh rate in Hz
SIMULACION, 0, when 1 the scan tick period becomes 4 cycles

Ports:
clk  input  1  peripheral clock (the 10 MHz domain)
reset  input  1  asynchronous, active-low reset
we  input  1  bus write strobe, one cycle per store
addr  input  1  register select: 0 = DATA, 1 = CTRL
wdata  input  32  bus write data
rdata  output  32  status readback: {30'b0, ovf, busy}
busy  output  1  decimal conversion in progress
SEG  output  7  segments {g,f,e,d,c,b,a}, active-low
AN  output  8  digit anodes, active-low, AN[0] = rightmost digit

Behaviour:
- Reset (reset=0, async):
  - AN=8'hFF, SEG=7'h7F, busy=0, rdata=0.
  - DATA=0, disp_buf=0.
  - CTRL: mode=hex, lzb=0, mask=8'hFF.
  - Scan index=0, divider=0.
- CTRL write (addr=1):
  - wdata[0] selects the mode: 0 = hex, 1 = dec.
  - wdata[1] = lzb, leading-zero blanking.
  - wdata[15:8] = digit enable mask.
  - Takes effect the next cycle. It does not re-convert DATA.
- DATA write, hex mode:
  - disp_buf <= wdata as 8 nibbles; visible from the next cycle.
  - ovf <= 0.
- DATA write, dec mode:
  - If wdata[31:16] != 0: ovf <= 1 and disp_buf <= all-dash pattern (segment g only) the next cycle. No conversion starts.
  - Otherwise, start sequential double-dabble on wdata[15:0]:
    - busy=1 from the cycle after the write.
    - One LOAD cycle, then 16 SHIFT cycles (add-3 then shift per cycle).
    - disp_buf <= 5 BCD digits, digits 5..7 blank. disp_buf and ovf=0 are updated on the cycle busy falls.
    - Total latency is 17 cycles from the write to busy=0.
  - The old disp_buf stays displayed until the conversion completes, so there is no partial-value glitch.
  - A DATA write during busy aborts the conversion and restarts with the new value (latency counted from the last write).
  - A CTRL write during busy does not disturb the conversion.
- Conversion FSM: IDLE -> LOAD -> SHIFT(x16, 4-bit iteration counter) -> DONE -> IDLE. DONE lasts one cycle and commits disp_buf.
- Leading-zero blanking (lzb=1):
  - A digit is blanked when it and all higher digits are 0.
  - Digit 0 is never blanked: value 0 shows "0".
  - Applies in both modes.
- Scan:
  - TICK_DIV = SIMULACION ? 4 : CLK_HZ/(REFRESH_HZ*8).
  - The divider counts 0..TICK_DIV-1. At wrap, idx <= idx+1 (mod 8, 7 wraps to 0).
  - AN and SEG are registered: they reflect idx one cycle after it changes.
  - AN = ~(8'b1<<idx) when mask[idx]=1, else 8'hFF with SEG=7'h7F.
- Decode (active-low):
  - Hex 0-F uses the standard pattern; A-F as A,b,C,d,E,F.
  - Blank = 7'h7F; dash = 7'h3F.
- rdata is registered and reflects busy/ovf with a one-cycle delay. Bus reads have no side effects.
- A reset mid-conversion returns the block to IDLE immediately and clears busy.

Decomposition:
- Package disp_pkg:
  - DATA/CTRL address constants.
  - Internal 5-bit digit-code typedef: 0-15 hex, BLANK, DASH.
  - Active-low segment pattern constants.
  - Decode function code -> SEG.
  - Mode enum {MODE_HEX, MODE_DEC}.
  - Conversion FSM state enum.
- Sub-module bin2bcd_seq:
  - Interface: start, 16-bit bin in; busy, done, 20-bit bcd out.
  - Holds the FSM and iteration counter.
  - The top keeps the registers, lzb logic, scan and decode.

Test Plan:
1. Reset then release (SIMULACION=1) -> AN=FF/SEG=7F during reset; afterwards idx steps every 4 cycles; AN walks FE,FD,...,7F and wraps to FE; with DATA=0 all digits show SEG=40.
2. Hex write DATA=32'h1234_ABCD -> digits 0..7 show D,C,B,A,4,3,2,1 (digit 0 SEG=21, digit 7 SEG=79); ovf=0.
3. CTRL=0x0000_FF03, then DATA=40 (0x28):
   - busy rises the cycle after the write and falls 17 cycles after it.
   - Digits show "40" (digit 1 SEG=19, digit 0 SEG=40); digits 2..7 are blank.
4. Dec mode, DATA=65535 -> digits "65535"; then DATA=0x0001_0000 -> ovf=1, busy stays 0, all enabled digits SEG=3F, rdata=2.
5. Dec DATA=12345, then DATA=7 issued 5 cycles later:
   - The display never shows 12345.
   - busy falls 17 cycles after the second write and the display shows "7".
6. CTRL mask=8'h0F -> AN stays FF and SEG=7F whenever idx is 4..7; reset asserted mid-conversion -> busy=0 and AN=FF asynchronously.
